// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and constants for the NPC memory arbiter
package npc_pkg;

  localparam int MASK_W = 8;
  localparam logic [31:0] RESP_ERR_DATA = 32'hdeadbeef;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/npc_rr_arb2.sv
// rtl/npc_rr_arb2.sv - two-way round-robin grant: bit 0 = IFU, bit 1 = LSU
module npc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant_ls,
  output logic [1:0] grant
);

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_ls ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// rtl/npc_mem_arbiter.sv - shares one memory port between IFU fetch and LSU load/store
module npc_mem_arbiter
  import npc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t         state;
  arb_state_t         state_nxt;
  owner_t             owner;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         grant;
  logic               timeout_hit;

  // The current owner doubles as the round-robin history.
  npc_rr_arb2 u_rr_arb2 (
    .req           ({ls_req_valid, if_req_valid}),
    .last_grant_ls (owner == OWN_LS),
    .grant         (grant)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_W'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if_req_ready = grant[0];
        ls_req_ready = grant[1];
        if (|grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if_resp_valid = (owner == OWN_IF);
          ls_resp_valid = (owner == OWN_LS);
          resp_rdata    = mem_wen ? '0 : mem_rdata;
          state_nxt     = IDLE;
        end else if (timeout_hit) begin
          if_resp_valid = (owner == OWN_IF);
          ls_resp_valid = (owner == OWN_LS);
          resp_rdata    = DATA_W'(RESP_ERR_DATA);
          resp_err      = 1'b1;
          state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        // A late response from the hung transaction is swallowed here.
        if (mem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      timer     <= '0;
    end else begin
      if (state == IDLE && grant[1]) begin
        owner     <= OWN_LS;
        mem_addr  <= ls_addr;
        mem_wen   <= ls_wen;
        mem_wdata <= ls_wdata;
        mem_wmask <= ls_wmask;
      end else if (state == IDLE && grant[0]) begin
        owner     <= OWN_IF;
        mem_addr  <= if_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end
      if (state == ISSUE && mem_req_ready) begin
        timer <= '0;
      end else if (state == WAIT && !mem_resp_valid && timer != {TIMER_W{1'b1}}) begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// tb/tb_npc_mem_arbiter.sv - scoreboard bench for npc_mem_arbiter with a behavioural memory
module tb_npc_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_addr;
  logic        ls_req_valid, ls_req_ready, ls_resp_valid, ls_wen;
  logic [31:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  typedef struct packed {
    logic        ls;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int          cfg_ready_lat = 0;
  int          cfg_resp_lat = 1;
  bit          cfg_no_resp = 0;
  bit          inject_resp = 0;
  int          m_stall = 0;
  int          resp_cnt = 0;
  int          mem_accepts = 0;
  logic [31:0] m_addr = '0;

  npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_resp_valid(ls_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a == 32'h80000000) ? 32'h00100073 : ({a[15:0], a[31:16]} ^ 32'h13579bdf);
  endfunction

  // Memory model: updates 2 time units after each rising edge.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      if (inject_resp) begin
        inject_resp = 0; mem_resp_valid = 1'b1; mem_rdata = 32'hcafef00d;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1; mem_rdata = mem_func(m_addr);
        end
      end else if (mem_req_valid && !rst) begin
        if (m_stall < cfg_ready_lat) m_stall++;
        else begin
          mem_req_ready = 1'b1; m_stall = 0; m_addr = mem_addr; mem_accepts++;
          resp_cnt = cfg_no_resp ? 0 : cfg_resp_lat;
        end
      end
    end
  end

  // Response monitor: every pulse pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_resp_valid || ls_resp_valid) begin
        checks++;
        if (if_resp_valid && ls_resp_valid) begin
          failures++; $display("FAIL resp_both if=1 ls=1 required one-hot");
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected if=%0b ls=%0b rdata=%h err=%0b required no pulse",
                   if_resp_valid, ls_resp_valid, resp_rdata, resp_err);
        end else begin
          e = sb.pop_front();
          if ({ls_resp_valid, resp_rdata, resp_err} !== e) begin
            failures++;
            $display("FAIL resp_data got ls=%0b rdata=%h err=%0b required ls=%0b rdata=%h err=%0b",
                     ls_resp_valid, resp_rdata, resp_err, e.ls, e.rdata, e.err);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit ls, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [7:0] wmask,
                       input bit exp_err, input bit exp_resp);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    if (ls) begin
      ls_req_valid = 1'b1; ls_addr = addr; ls_wen = wen; ls_wdata = wdata; ls_wmask = wmask;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(ls ? ls_req_ready : if_req_ready) && n < 50);
    checks++;
    if (!(ls ? ls_req_ready : if_req_ready)) begin
      failures++; $display("FAIL issue_grant addr=%h ready=0 required=1", addr);
    end else if (exp_resp) begin
      e.ls    = ls;
      e.err   = exp_err;
      e.rdata = exp_err ? 32'hdeadbeef : ((ls && wen) ? 32'h0 : mem_func(addr));
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (ls) begin
      ls_req_valid = 1'b0; ls_addr = 32'hbad0bad0; ls_wen = ~wen; ls_wdata = ~wdata; ls_wmask = ~wmask;
    end else begin
      if_req_valid = 1'b0; if_addr = 32'hbad0bad0;
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((busy || sb.size() != 0) && n < 100);
    checks++;
    if (busy || sb.size() != 0) begin
      failures++; $display("FAIL wait_idle busy=%0b pending=%0d required busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, resp_rdata, resp_err, mem_req_valid} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h required=0",
        {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, resp_rdata, resp_err, mem_req_valid});
    end
    checks++;
    if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      failures++; $display("FAIL reset_fields addr=%h wen=%0b wdata=%h wmask=%h required 0",
                           mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b required=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ifu_fetch;
    int pulses, at;
    cfg_ready_lat = 0; cfg_resp_lat = 2; cfg_no_resp = 0;
    issue(0, 32'h80000000, 1'b0, 32'h0, 8'h0, 0, 1);
    pulses = 0; at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({mem_req_valid, mem_req_ready, mem_addr, mem_wen, mem_wmask} !== {1'b1, 1'b1, 32'h80000000, 1'b0, 8'h00}) begin
          failures++; $display("FAIL ifu_mem_req valid=%0b ready=%0b addr=%h wen=%0b wmask=%h required 1 1 80000000 0 00",
                               mem_req_valid, mem_req_ready, mem_addr, mem_wen, mem_wmask);
        end
      end
      if (if_resp_valid) begin pulses++; at = i; end
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL ifu_pulse_count got=%0d required=1", pulses); end
    checks++;
    if (at !== 3) begin failures++; $display("FAIL ifu_latency got=%0d required=3", at); end
    wait_idle();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   grants, cyc, last_cyc;
    bit   exp_ls, got_ls;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    cfg_ready_lat = 0; cfg_resp_lat = 1;
    if_req_valid = 1'b1; if_addr = 32'h80001000;
    ls_req_valid = 1'b1; ls_addr = 32'h80002000; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    grants = 0; cyc = 0; last_cyc = 0; exp_ls = 1'b1;
    while (grants < 10 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (if_req_ready || ls_req_ready) begin
        got_ls = ls_req_ready;
        checks++;
        if ((if_req_ready && ls_req_ready) || got_ls !== exp_ls) begin
          failures++; $display("FAIL rr_order grant=%0d if_ready=%0b ls_ready=%0b required ls=%0b",
                               grants, if_req_ready, ls_req_ready, exp_ls);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_cyc !== 3) begin
            failures++; $display("FAIL rr_gap grant=%0d got=%0d required=3", grants, cyc - last_cyc);
          end
        end
        e.ls = got_ls; e.err = 1'b0;
        e.rdata = mem_func(got_ls ? ls_addr : if_addr);
        sb.push_back(e);
        last_cyc = cyc; grants++; exp_ls = ~exp_ls;
        @(posedge clk); #1;
        if (got_ls) ls_addr = ls_addr + 32'd4; else if_addr = if_addr + 32'd4;
      end
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    checks++;
    if (grants !== 10) begin failures++; $display("FAIL rr_grants got=%0d required=10", grants); end
    wait_idle();
  endtask

  task automatic test_store_stall;
    int stall, pulse_at;
    cfg_ready_lat = 3; cfg_resp_lat = 1;
    issue(1, 32'h80000100, 1'b1, 32'h12345678, 8'h0f, 0, 1);
    stall = 0; pulse_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        checks++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {32'h80000100, 1'b1, 32'h12345678, 8'h0f}) begin
          failures++; $display("FAIL store_fields cyc=%0d addr=%h wen=%0b wdata=%h wmask=%h required 80000100 1 12345678 0f",
                               i, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        if (!mem_req_ready) stall++;
      end
      if (ls_resp_valid) pulse_at = i;
    end
    checks++;
    if (stall !== 3) begin failures++; $display("FAIL store_stall got=%0d required=3", stall); end
    checks++;
    if (pulse_at !== 5) begin failures++; $display("FAIL store_resp_cycle got=%0d required=5", pulse_at); end
    cfg_ready_lat = 0;
    wait_idle();
  endtask

  task automatic test_timeout;
    int  pulse_at;
    bit  bad;
    cfg_ready_lat = 0; cfg_no_resp = 1;
    issue(1, 32'h80000200, 1'b0, 32'h0, 8'h0, 1, 1);
    pulse_at = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ls_resp_valid) pulse_at = i;
    end
    checks++;
    if (pulse_at !== 5) begin failures++; $display("FAIL timeout_cycle got=%0d required=5", pulse_at); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy got=%0b required=1", busy); end
    @(posedge clk); #1; if_req_valid = 1'b1; if_addr = 32'h80000280;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_req_ready || mem_req_valid) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL drain_blocks got=grant required=no grant"); end
    @(posedge clk); #1; if_req_valid = 1'b0; inject_resp = 1;
    @(negedge clk);
    checks++;
    if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin
      failures++; $display("FAIL drain_pulse got=%b required=00", {if_resp_valid, ls_resp_valid});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drain_exit busy=%0b required=0", busy); end
    cfg_no_resp = 0;
    wait_idle();
  endtask

  task automatic test_reset_in_wait;
    bit bad;
    cfg_ready_lat = 0; cfg_resp_lat = 3;
    issue(0, 32'h80000300, 1'b0, 32'h0, 8'h0, 0, 0);
    @(negedge clk);
    checks++;
    if ({mem_req_valid, mem_req_ready} !== 2'b11) begin
      failures++; $display("FAIL rstw_accept got=%b required=11", {mem_req_valid, mem_req_ready});
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstw_in_wait busy=%0b required=1", busy); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstw_idle busy=%0b required=0", busy); end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_resp_valid || ls_resp_valid || busy) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL rstw_stale_resp got=activity required=quiet"); end
    cfg_resp_lat = 1;
    issue(0, 32'h80000304, 1'b0, 32'h0, 8'h0, 0, 1);
    wait_idle();
  endtask

  task automatic test_withdraw;
    int  acc0;
    bit  bad;
    cfg_ready_lat = 0; cfg_resp_lat = 3;
    acc0 = mem_accepts;
    issue(1, 32'h80000400, 1'b0, 32'h0, 8'h0, 0, 1);
    if_req_valid = 1'b1; if_addr = 32'h80000500;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (if_req_ready) bad = 1;
    end
    @(posedge clk); #1; if_req_valid = 1'b0;
    checks++;
    if (bad) begin failures++; $display("FAIL withdraw_ready got=1 required=0"); end
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (mem_accepts - acc0 !== 1) begin
      failures++; $display("FAIL withdraw_mem_reqs got=%0d required=1", mem_accepts - acc0);
    end
    checks++;
    if (m_addr !== 32'h80000400) begin failures++; $display("FAIL withdraw_addr got=%h required=80000400", m_addr); end
    cfg_resp_lat = 1;
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    test_reset();
    test_ifu_fetch();
    test_back_to_back();
    test_store_stall();
    test_timeout();
    test_reset_in_wait();
    test_withdraw();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
